regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with dual writeback ports and a per-register busy scoreboard.
// Reads are combinational with optional same-cycle forwarding from the write ports.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic                wr_conflict
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  // An address is live when it is in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic wa_ok, wb_ok, iss_ok, collide;
  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] busy_reg, busy_next;
  logic [NREG-1:0] wr_hit, iss_hit;
  logic            wr_conflict_reg;

  // Port B wins a same-address collision, so port A is suppressed outright.
  assign wb_ok   = wb_en && addr_ok(wb_addr);
  assign wa_ok   = wa_en && addr_ok(wa_addr) && !(wb_ok && (wb_addr == wa_addr));
  assign iss_ok  = iss_en && addr_ok(iss_addr);
  assign collide = wa_en && wb_en && (wa_addr == wb_addr) && addr_ok(wa_addr);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);
      assign wr_hit[gi]  = (wb_ok && (wb_addr == IDX)) || (wa_ok && (wa_addr == IDX));
      assign iss_hit[gi] = iss_ok && (iss_addr == IDX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (wb_ok && (wb_addr == IDX)) begin
          regs_reg[gi] <= wb_data;
        end else if (wa_ok && (wa_addr == IDX)) begin
          regs_reg[gi] <= wa_data;
        end
      end
    end
  endgenerate

  // A same-cycle issue marks a newer producer, so it overrides the write's clear.
  assign busy_next = (busy_reg & ~wr_hit) | iss_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg        <= '0;
      wr_conflict_reg <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      wr_conflict_reg <= collide;
    end
  end

  assign busy_vec    = busy_reg;
  assign wr_conflict = wr_conflict_reg;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            rbusy;
      logic            hit_a, hit_b, hit_iss;

      assign ra      = rd_addr[gi*AW +: AW];
      assign hit_b   = wb_ok && (wb_addr == ra);
      assign hit_a   = wa_ok && (wa_addr == ra);
      assign hit_iss = iss_ok && (iss_addr == ra);

      always_comb begin
        rdat  = '0;
        rbusy = 1'b0;
        if (addr_ok(ra)) begin
          rdat  = regs_reg[ra];
          rbusy = busy_reg[ra];
          if (BYPASS != 0) begin
            if (hit_b) begin
              rdat = wb_data;
            end else if (hit_a) begin
              rdat = wa_data;
            end
            if ((hit_a || hit_b) && !hit_iss) begin
              rbusy = 1'b0;
            end
          end
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = rdat;
      assign rd_busy[gi]              = rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances (default, no-bypass, 24-register) share stimulus
// and are checked every cycle against an array-based model plus directed literal checks.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        wa_en, wb_en, iss_en;
  logic [4:0]  wa_addr, wb_addr, iss_addr;
  logic [31:0] wa_data, wb_data;

  logic [63:0] rd_data_a, rd_data_b, rd_data_c;
  logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
  logic [31:0] busy_a, busy_b;
  logic [23:0] busy_c;
  logic        conf_a, conf_b, conf_c;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_a), .wr_conflict(conf_a));

  regfile_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_b), .wr_conflict(conf_b));

  regfile_sb #(.NREG(24)) u_small (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_c), .wr_conflict(conf_c));

  // ---------------- model: k=0 default, k=1 no bypass, k=2 NREG=24 ----------------
  logic [31:0] m_regs [3][32];
  bit          m_busy [3][32];
  bit          m_conf [3];

  function automatic int nreg_of(input int k);
    return (k == 2) ? 24 : 32;
  endfunction

  function automatic bit live(input int k, input int a);
    return (a != 0) && (a < nreg_of(k));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_conf[k] <= 1'b0;
        for (int r = 0; r < 32; r++) begin
          m_regs[k][r] <= '0;
          m_busy[k][r] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        // later assignments win: B after A, issue after write clear
        if (wa_en && live(k, int'(wa_addr))) begin
          m_regs[k][wa_addr] <= wa_data;
          m_busy[k][wa_addr] <= 1'b0;
        end
        if (wb_en && live(k, int'(wb_addr))) begin
          m_regs[k][wb_addr] <= wb_data;
          m_busy[k][wb_addr] <= 1'b0;
        end
        if (iss_en && live(k, int'(iss_addr))) m_busy[k][iss_addr] <= 1'b1;
        m_conf[k] <= wa_en && wb_en && (wa_addr == wb_addr) && live(k, int'(wa_addr));
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int k, input int a);
    if (!live(k, a)) return '0;
    if (k != 1 && wb_en && int'(wb_addr) == a) return wb_data;
    if (k != 1 && wa_en && int'(wa_addr) == a) return wa_data;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input int a);
    bit wr;
    if (!live(k, a)) return 1'b0;
    wr = (wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a);
    if (k != 1 && wr && !(iss_en && int'(iss_addr) == a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [31:0] dut_rd(input int k, input int p);
    logic [63:0] v;
    v = (k == 0) ? rd_data_a : (k == 1) ? rd_data_b : rd_data_c;
    return v[p*32 +: 32];
  endfunction

  function automatic logic dut_rbusy(input int k, input int p);
    logic [1:0] v;
    v = (k == 0) ? rd_busy_a : (k == 1) ? rd_busy_b : rd_busy_c;
    return v[p];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] mb, db;
        logic        dc;
        for (int p = 0; p < 2; p++) begin
          int a;
          a = int'(rd_addr[p*5 +: 5]);
          chk($sformatf("cyc_rd_data k%0d p%0d a%0d", k, p, a), 64'(dut_rd(k, p)), 64'(exp_rd(k, a)));
          chk($sformatf("cyc_rd_busy k%0d p%0d a%0d", k, p, a), 64'(dut_rbusy(k, p)), 64'(exp_busy(k, a)));
        end
        mb = '0;
        for (int r = 0; r < nreg_of(k); r++) mb[r] = m_busy[k][r];
        db = (k == 0) ? busy_a : (k == 1) ? busy_b : 32'(busy_c);
        dc = (k == 0) ? conf_a : (k == 1) ? conf_b : conf_c;
        chk($sformatf("cyc_busy_vec k%0d", k), 64'(db), 64'(mb));
        chk($sformatf("cyc_wr_conflict k%0d", k), 64'(dc), 64'(m_conf[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0;
  endtask

  initial begin
    rst_n = 1; rd_addr = '0; idle();
    wa_addr = '0; wb_addr = '0; iss_addr = '0; wa_data = '0; wb_data = '0;
    #2 rst_n = 0;
    #1 chk_on = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state across every address
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #2;
      chk($sformatf("rst_rd_data a%0d", a), rd_data_a, 64'h0);
      chk($sformatf("rst_flags a%0d", a), {busy_a, rd_busy_a, conf_a}, 64'h0);
      tick();
    end

    // forwarding: bypass instance sees the write now, the other only next cycle
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #2;
    chk("byp_same_cycle", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    chk("nobyp_same_cycle", 64'(rd_data_b[31:0]), 64'h0);
    tick(); idle(); #1;
    chk("byp_next_cycle", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    chk("nobyp_next_cycle", 64'(rd_data_b[31:0]), 64'hDEADBEEF);

    // dual write collision on address 7
    wa_en = 1; wa_addr = 7; wa_data = 32'h11; wb_en = 1; wb_addr = 7; wb_data = 32'h22;
    rd_addr = {5'd0, 5'd7};
    #2 chk("conflict_before", 64'(conf_a), 64'h0);
    tick(); idle(); #1;
    chk("conflict_pulse", 64'(conf_a), 64'h1);
    chk("collide_b_wins", 64'(rd_data_b[31:0]), 64'h22);
    tick();
    chk("conflict_one_cycle", 64'(conf_a), 64'h0);

    // scoreboard on register 9
    iss_en = 1; iss_addr = 9; rd_addr = {5'd9, 5'd0};
    tick(); idle();
    chk("busy9_issue", 64'(busy_a[9]), 64'h1);
    tick(); chk("busy9_idle1", 64'(busy_a[9]), 64'h1);
    tick(); chk("busy9_idle2", 64'(busy_a[9]), 64'h1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h99; iss_en = 1; iss_addr = 9;
    #1 chk("rd_busy9_reissue", 64'(rd_busy_a[1]), 64'h1);
    tick(); idle();
    chk("busy9_reissued", 64'(busy_a[9]), 64'h1);
    tick(); chk("busy9_stays", 64'(busy_a[9]), 64'h1);
    wa_en = 1; wa_addr = 9; wa_data = 32'h9A;
    #1 chk("rd_busy9_bypass_clear", 64'(rd_busy_a[1]), 64'h0);
    chk("rd_busy9_nobyp", 64'(rd_busy_b[1]), 64'h1);
    tick(); idle();
    chk("busy9_cleared", 64'(busy_a[9]), 64'h0);

    // register 0 is hardwired
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0; rd_addr = {5'd0, 5'd0};
    #1 chk("zero_same_cycle", 64'(rd_data_a[31:0]), 64'h0);
    tick(); idle();
    chk("zero_read", rd_data_a, 64'h0);
    chk("zero_busy_conf", {busy_a[0], conf_a}, 64'h0);

    // bulk traffic on both ports with issues; model checks each cycle
    for (int a = 1; a < 32; a++) begin
      wa_en = 1; wa_addr = 5'(a); wa_data = 32'h01010101 * a;
      wb_en = (a % 3 == 0); wb_addr = 5'((a * 7) % 32); wb_data = ~32'(a);
      iss_en = (a % 4 == 1); iss_addr = 5'((a + 2) % 32);
      rd_addr = {5'(a), 5'((a * 5) % 32)};
      tick();
    end
    idle();

    // address 30 exists in the default instance but not in the 24-register one
    rd_addr = {5'd3, 5'd30};
    #1;
    chk("a30_small", 64'(rd_data_c[31:0]), 64'h0);
    chk("a30_full", 64'(rd_data_a[31:0]), 64'h1E1E1E1E);
    chk("a30_small_busy", 64'(rd_busy_c[0]), 64'h0);
    tick();

    // collision, then reset dropped between edges kills the pulse and all state
    wa_en = 1; wa_addr = 3; wa_data = 32'hAAAA; wb_en = 1; wb_addr = 3; wb_data = 32'hBBBB;
    tick(); idle();
    #1 chk("conf_before_reset", 64'(conf_a), 64'h1);
    chk("rd3_before_reset", 64'(rd_data_a[63:32]), 64'hBBBB);
    rst_n = 0;
    #1;
    chk("async_rst_conf", 64'(conf_a), 64'h0);
    chk("async_rst_busy", 64'(busy_a), 64'h0);
    chk("async_rst_rd", rd_data_a, 64'h0);
    chk("async_rst_small", rd_data_c, 64'h0);

    // writes while held in reset are lost
    wa_en = 1; wa_addr = 4; wa_data = 32'h4444; iss_en = 1; iss_addr = 4; rd_addr = {5'd4, 5'd4};
    tick(); idle();
    rst_n = 1;
    tick();
    chk("held_rst_write_lost", 64'(rd_data_a[31:0]), 64'h0);
    chk("held_rst_issue_lost", 64'(busy_a[4]), 64'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
